// File: rtl/rgbw_pkg.sv
// rtl/rgbw_pkg.sv - shared constants, per-channel direction type and perceptual curve for the RGBW slew limiter
package rgbw_pkg;

  localparam int DUTY_W = 8;
  localparam int NUM_CH = 4;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;
  localparam int CH_W = 3;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  // (d*(d+1)) >> DUTY_W keeps full scale at full scale (255 -> 255) and halves mid-scale.
  function automatic logic [DUTY_W-1:0] gamma(input logic [DUTY_W-1:0] d);
    logic [2*DUTY_W-1:0] wide;
    logic [2*DUTY_W-1:0] prod;
    wide = {{DUTY_W{1'b0}}, d};
    prod = wide * (wide + {{(2*DUTY_W-1){1'b0}}, 1'b1});
    return prod[2*DUTY_W-1:DUTY_W];
  endfunction

endpackage

// File: rtl/rgbw_slew_ch.sv
// rtl/rgbw_slew_ch.sv - one slewed duty channel: register, compare and +/-1 step toward target
module rgbw_slew_ch #(
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              snap,
  input  logic              tick,
  input  logic [DUTY_W-1:0] target,
  output logic [DUTY_W-1:0] duty,
  output logic              eq
);
  import rgbw_pkg::*;

  localparam logic [DUTY_W-1:0] ONE = {{(DUTY_W-1){1'b0}}, 1'b1};

  dir_e              dir;
  logic [DUTY_W-1:0] duty_next;

  always_comb begin
    dir = DIR_HOLD;
    if (duty < target) begin
      dir = DIR_UP;
    end else if (duty > target) begin
      dir = DIR_DOWN;
    end
  end

  // Snap overrides any pending step; a step can never pass the target since it only moves toward it.
  always_comb begin
    duty_next = duty;
    if (snap) begin
      duty_next = target;
    end else if (tick) begin
      case (dir)
        DIR_UP:   duty_next = duty + ONE;
        DIR_DOWN: duty_next = duty - ONE;
        default:  duty_next = duty;
      endcase
    end
  end

  assign eq = (duty_next == target);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty <= '0;
    end else begin
      duty <= duty_next;
    end
  end

endmodule

// File: rtl/rgbw_duty_slew.sv
// rtl/rgbw_duty_slew.sv - RGBW duty slew limiter top; RGBW_SLEW_GAMMA_EN adds a registered perceptual curve stage
module rgbw_duty_slew #(
  parameter int DUTY_W = rgbw_pkg::DUTY_W,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              snap,
  input  logic [DIV_W-1:0]  tick_div,
  input  logic [DUTY_W-1:0] target0,
  input  logic [DUTY_W-1:0] target1,
  input  logic [DUTY_W-1:0] target2,
  input  logic [DUTY_W-1:0] target3,
  output logic [DUTY_W-1:0] duty0,
  output logic [DUTY_W-1:0] duty1,
  output logic [DUTY_W-1:0] duty2,
  output logic [DUTY_W-1:0] duty3,
  output logic              settled
);
  import rgbw_pkg::*;

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0]  cnt;
  logic              tick;
  logic [DUTY_W-1:0] target [NUM_CH];
  logic [DUTY_W-1:0] duty_q [NUM_CH];
  logic [NUM_CH-1:0] eq;
  logic              settled_raw;

  assign target[CH_R] = target0;
  assign target[CH_G] = target1;
  assign target[CH_B] = target2;
  assign target[CH_W] = target3;

  // >= rather than == so that lowering tick_div below cnt wraps on the very next edge.
  assign tick = en && (cnt >= tick_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (snap) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : (cnt + CNT_ONE);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rgbw_slew_ch #(
      .DUTY_W (DUTY_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .snap   (snap),
      .tick   (tick),
      .target (target[i]),
      .duty   (duty_q[i]),
      .eq     (eq[i])
    );
  end

  // Evaluated from next-state duties every cycle, independent of en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settled_raw <= 1'b0;
    end else begin
      settled_raw <= &eq;
    end
  end

`ifdef RGBW_SLEW_GAMMA_EN
  logic [DUTY_W-1:0] curve_q [NUM_CH];
  logic              settled_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        curve_q[i] <= '0;
      end
      settled_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        curve_q[i] <= gamma(duty_q[i]);
      end
      settled_q <= settled_raw;
    end
  end

  assign duty0   = curve_q[CH_R];
  assign duty1   = curve_q[CH_G];
  assign duty2   = curve_q[CH_B];
  assign duty3   = curve_q[CH_W];
  assign settled = settled_q;
`else
  assign duty0   = duty_q[CH_R];
  assign duty1   = duty_q[CH_G];
  assign duty2   = duty_q[CH_B];
  assign duty3   = duty_q[CH_W];
  assign settled = settled_raw;
`endif

endmodule

// File: doc/rgbw_duty_slew.md
# rgbw_duty_slew

Per-channel duty slew limiter between the colour generator and the PWM generator. It takes four 8-bit target duties (R, G, B, W) and moves four registered output duties toward them by one LSB per slew tick, so that colour and intensity changes fade smoothly instead of stepping. The tick rate is programmable, and a snap input bypasses the ramp.

## Interface
- `DUTY_W`, 8: duty width per channel.
- `DIV_W`, 16: width of the tick divider.
- `clk`  in  1  system clock, the same prescaled clock that drives colour generation and PWM.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  slew enable; low freezes the tick counter and all duties.
- `snap`  in  1  single-cycle pulse; loads the targets directly.
- `tick_div`  in  DIV_W  tick period is `tick_div+1` clk cycles.
- `target0..target3`  in  DUTY_W each  target duties for R, G, B, W.
- `duty0..duty3`  out  DUTY_W each  slewed duties, sent to the PWM generator.
- `settled`  out  1  high when all four duties equal their targets.

## Operation
- **Tick counter `cnt`** (DIV_W bits):
  - When `en`=1 it increments each cycle.
  - When `cnt >= tick_div` it asserts an internal `tick` and wraps to 0 on the same edge.
  - If `tick_div` is lowered below the current `cnt`, the counter wraps on the next edge and produces a tick.
  - `tick_div`=0 gives a tick every cycle.
- **Per-channel step on tick:**
  - If duty < target: duty+1.
  - If duty > target: duty−1.
  - If equal: hold.
  - No overflow is possible; a duty never passes its target.
- **Target changes** mid-ramp take effect at the next tick. There is no restart and no reversal delay.
- **`snap`**, which has priority over tick and is independent of `en`:
  - All duties load their targets on the next edge.
  - `cnt` clears to 0.
- **`en`=0:** `cnt` and the duties hold. `settled` keeps being evaluated.
- **`settled`:** registered each cycle from the next-state duties, `&(duty_next[i] == target[i])`.
- **States per channel:** UP, DOWN or HOLD, decoded from the compare result. There is no explicit FSM register.

## Timing
- **Reset values:** `duty0..3`=0, `cnt`=0, `settled`=0. On the first edge after reset release, `settled` reflects the comparison.
- **Step latency:** a duty changes on the edge on which `tick` is high. With a constant `tick_div`=N, consecutive steps are N+1 cycles apart.
- **Snap latency:** 1 cycle from `snap` to the duties equal to the targets. `settled` is high on the same edge.
- **Full ramp 0→255:** 255 ticks, i.e. 255·(N+1) cycles.
- **Reset during a ramp:** the duties drop to 0 immediately (asynchronously). After release, the ramp restarts from 0 toward the current targets.
- **Snap and tick in the same cycle:** snap wins, and no extra step is applied.
- **Target equal to duty at a tick:** hold, and `settled` stays high.

## Configuration
- **`RGBW_SLEW_GAMMA_EN` defined:**
  - Each output passes through a perceptual curve, `out = (d·(d+1)) >> 8`. This maps 0→0, 128→64 and 255→255.
  - The curve output is registered, adding 1 cycle of latency on `duty0..3`; the reset value of that register is 0.
  - `settled` is delayed by the same extra cycle so that it stays aligned with the outputs.
- **Not defined:** the slewed duties drive the outputs directly with no extra stage. The curve logic is absent.

## Structure
- **Shared package `rgbw_pkg`:**
  - `DUTY_W` and `NUM_CH`=4.
  - Channel index constants `CH_R`=0, `CH_G`=1, `CH_B`=2, `CH_W`=3.
  - The gamma function for use under the macro.
- **Sub-module `rgbw_slew_ch`:** one instance per channel. It holds the duty register, the compare and the ±1 step, and outputs `eq`. The top holds the tick counter, the snap and enable logic, and `settled`.

## Test plan
- **Reset:** assert `reset` with targets=8'hFF → all duties 0, `settled`=0. Release with targets=0 → `settled`=1 on the next edge.
- **Ramp up:** `tick_div`=3, target0 changes 0→5 → duty0 steps 1,2,3,4,5 at 4-cycle intervals. `settled` is high on the edge where duty0=5. The other channels hold.
- **Ramp down with retarget:** duty1=200, target1=190, `tick_div`=0 → decrements each cycle. After 4 cycles, change target1 to 198 → duty1 rises back from 196 to 198.
- **Snap:** mid-ramp, with targets (10,20,30,40) and a `snap` pulse → next edge duties=(10,20,30,40), `cnt`=0, `settled`=1. A tick in the same cycle does not add a step.
- **Divider change and enable:** `cnt`=9 with `tick_div`=20, then `tick_div` changes to 5 → a tick on the next edge, then one every 6 cycles. `en`=0 for 10 cycles → duties frozen.
- **Gamma (macro on):** snap the targets to (0,128,255,64) → after 2 cycles the outputs are (0,64,255,16).
